// File: rtl/lsu_unit.sv
// Load/store unit for one thread. It issues a single memory request per
// instruction, waits for the handshake or a timeout, and holds the result until UPDATE.
module lsu_unit #(
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    localparam int unsigned CNT_BITS   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST_COUNT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [2:0]  CORE_REQUEST = 3'b011;
    localparam logic [2:0]  CORE_UPDATE  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE       = 2'b00,
        S_REQUESTING = 2'b01,
        S_WAITING    = 2'b10,
        S_DONE       = 2'b11
    } state_t;

    state_t                r_state,  w_state;
    logic                  r_is_load, w_is_load;
    logic                  r_rvalid, w_rvalid;
    logic                  r_wvalid, w_wvalid;
    logic [ADDR_BITS-1:0]  r_addr,   w_addr;
    logic [DATA_BITS-1:0]  r_wdata,  w_wdata;
    logic [DATA_BITS-1:0]  r_out,    w_out;
    logic                  r_error,  w_error;
    logic [CNT_BITS-1:0]   r_count,  w_count;
    logic                  w_ready;

    // Next-state and next-register logic; enable low leaves everything at its default (hold).
    always_comb begin
        w_state   = r_state;
        w_is_load = r_is_load;
        w_rvalid  = r_rvalid;
        w_wvalid  = r_wvalid;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_out     = r_out;
        w_error   = r_error;
        w_count   = r_count;
        w_ready   = r_is_load ? mem_read_ready : mem_write_ready;

        if (enable) begin
            unique case (r_state)
                S_IDLE: begin
                    if ((core_state == CORE_REQUEST) &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        w_state   = S_REQUESTING;
                        w_error   = 1'b0;
                        w_is_load = decoded_mem_read_enable;
                    end
                end
                S_REQUESTING: begin
                    // Operands are only valid here, one cycle after the register file updates.
                    w_addr  = ADDR_BITS'(rs);
                    w_count = '0;
                    if (r_is_load) begin
                        w_rvalid = 1'b1;
                    end else begin
                        w_wvalid = 1'b1;
                        w_wdata  = rt;
                    end
                    w_state = S_WAITING;
                end
                S_WAITING: begin
                    if (w_ready) begin
                        w_rvalid = 1'b0;
                        w_wvalid = 1'b0;
                        if (r_is_load) begin
                            w_out = mem_read_data;
                        end
                        w_state = S_DONE;
                    end else if (TIMEOUT_EN && (r_count == CNT_BITS'(LAST_COUNT))) begin
                        w_rvalid = 1'b0;
                        w_wvalid = 1'b0;
                        w_error  = 1'b1;
                        if (r_is_load) begin
                            w_out = '0;
                        end
                        w_state = S_DONE;
                    end else begin
                        w_count = r_count + CNT_BITS'(1);
                    end
                end
                S_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        w_state = S_IDLE;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    // State register; reset overrides enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_is_load <= 1'b0;
            r_rvalid  <= 1'b0;
            r_wvalid  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_out     <= '0;
            r_error   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state;
            r_is_load <= w_is_load;
            r_rvalid  <= w_rvalid;
            r_wvalid  <= w_wvalid;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_out     <= w_out;
            r_error   <= w_error;
            r_count   <= w_count;
        end
    end

    assign mem_read_valid    = r_rvalid;
    assign mem_read_address  = r_addr;
    assign mem_write_valid   = r_wvalid;
    assign mem_write_address = r_addr;
    assign mem_write_data    = r_wdata;
    assign lsu_state         = r_state;
    assign lsu_out           = r_out;
    assign lsu_error         = r_error;

endmodule

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 Parameter: DATA_BITS, default 32, width of rs, rt, lsu_out and memory data.
REQ-002 Parameter: ADDR_BITS, default 8, width of memory addresses.
REQ-003 Parameter: TIMEOUT_CYCLES, default 255, WAITING-cycle limit before abort; 0 SHALL disable the timeout.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  thread-active qualifier; when low, all state and outputs SHALL hold.
REQ-007 core_state  in  3  core phase (REQUEST=3'b011, UPDATE=3'b110; other codes are ignored).
REQ-008 decoded_mem_read_enable  in  1  current instruction is a load.
REQ-009 decoded_mem_write_enable  in  1  current instruction is a store.
REQ-010 rs  in  DATA_BITS  address operand from the thread register file.
REQ-011 rt  in  DATA_BITS  store-data operand from the thread register file.
REQ-012 mem_read_valid / mem_read_address  out  1 / ADDR_BITS  load request to the memory controller.
REQ-013 mem_read_ready / mem_read_data  in  1 / DATA_BITS  load completion from the memory controller.
REQ-014 mem_write_valid / mem_write_address / mem_write_data  out  1 / ADDR_BITS / DATA_BITS  store request.
REQ-015 mem_write_ready  in  1  store completion.
REQ-016 lsu_state  out  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
REQ-017 lsu_out  out  DATA_BITS  load result, written back to the register file MEMORY path.
REQ-018 lsu_error  out  1  the last transaction aborted on timeout.

Function
REQ-019 IDLE: if core_state==REQUEST and either enable is set, the block SHALL go to REQUESTING and clear lsu_error; otherwise it SHALL stay in IDLE.
REQ-020 Read and write enables both set: the block SHALL treat the instruction as a load only; no write request SHALL issue.
REQ-021 REQUESTING (1 cycle): the block SHALL register address=rs[ADDR_BITS-1:0] (upper bits truncated without error), assert the matching valid on the next edge, latch rt as write data for a store, clear the timeout counter, and go to WAITING.
REQ-022 rs/rt SHALL be sampled in REQUESTING, one cycle after REQUEST, because the register file updates rs/rt on the REQUEST edge.
REQ-023 WAITING: valid, address and data SHALL stay stable until ready is seen.
REQ-024 Read ready seen: the block SHALL deassert mem_read_valid, capture lsu_out=mem_read_data, and go to DONE on the same edge.
REQ-025 Write ready seen: the block SHALL deassert mem_write_valid, leave lsu_out unchanged, and go to DONE.
REQ-026 Ready of the non-active channel SHALL be ignored.
REQ-027 Timeout counter: the counter SHALL increment each enabled WAITING cycle without ready.
REQ-028 Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no ready, the block SHALL deassert valid, set lsu_error=1, set lsu_out=0 for a load, and go to DONE.
REQ-029 Ready on the timeout cycle: ready SHALL win, with no error.
REQ-030 DONE: the block SHALL hold lsu_out until core_state==UPDATE, then go to IDLE. lsu_out SHALL keep its value in IDLE.
REQ-031 core_state codes other than REQUEST and UPDATE SHALL NOT affect the FSM, except that WAITING SHALL advance as specified regardless of core_state.
REQ-032 enable low mid-transaction: the block SHALL freeze state, the counter and valid; any ready arriving during the freeze SHALL be ignored.
REQ-033 At most one transaction SHALL be outstanding; both valids SHALL never be high together.

Reset
REQ-034 On reset the block SHALL set lsu_state=IDLE, both valids=0, both addresses=0, mem_write_data=0, lsu_out=0, lsu_error=0 and the counter=0.
REQ-035 Reset asserted in any state, including WAITING with valid high, SHALL take effect on the next edge and drop valid with no handshake.
REQ-036 Reset SHALL take priority over enable.

Verification
REQ-037 Load: REQUEST with read=1, rs=0x00000012; memory ready after 3 cycles with data 0xDEADBEEF -> mem_read_address=0x12, valid high until ready, lsu_out=0xDEADBEEF in DONE, IDLE after UPDATE.
REQ-038 Store: rs=0x34, rt=0x5A5A0001, ready after 1 cycle -> mem_write_address=0x34, mem_write_data=0x5A5A0001, lsu_out unchanged, mem_read_valid never high.
REQ-039 Timeout: TIMEOUT_CYCLES=4, load with ready never asserted -> valid drops after 4 WAITING cycles, lsu_error=1, lsu_out=0; the next REQUEST clears lsu_error.
REQ-040 Both enables set, rs=0x1FF -> read only, address=0xFF (truncated), no write valid.
REQ-041 enable low for 5 cycles in WAITING with ready pulsed -> state, counter and valid frozen; completion occurs only on a ready after enable returns.
REQ-042 Reset in WAITING with mem_read_valid=1 -> next cycle all outputs at reset values, lsu_state=IDLE.
